io_encoder_writer: RTL and testbench
====================================

# io_encoder_writer

Input-direction peripheral on the RAM IO port. Samples a two-channel quadrature encoder from external pins and decodes it into a signed 32-bit position. On a fixed period it publishes the position and a status word into the processor's data memory. It also polls a command mailbox so software can zero the count. Outbound IO logic reads memory words and drives pins; this block does the reverse, turning pin activity into memory writes that the processor reads with `lw`.

## Interface
- `UPDATE_CYCLES`, 100000: clock cycles between publish sequences (1 kHz at 100 MHz); must be ≥ 8.
- `POS_ADDR`, 12'd4000: RAM word address for the position.
- `STATUS_ADDR`, 12'd4001: RAM word address for the status word.
- `CMD_ADDR`, 12'd4002: RAM word address for the command mailbox.

Ports:
- `clk` in 1: single clock; all state is on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `enc_a` in 1: encoder channel A; asynchronous.
- `enc_b` in 1: encoder channel B; asynchronous.
- `IO_dataIn` in 32: RAM IO read data, valid the cycle after `IO_addr` is presented.
- `IO_addr` out 12: RAM IO word address.
- `IO_dataOut` out 32: RAM IO write data.
- `IO_wEn` out 1: RAM IO write enable; the write commits on the rising edge while high.
- `position` out 32: live decoded position, for debug LEDs.
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation
- Input path: `enc_a` and `enc_b` each pass through a 2-FF synchronizer, giving `{a_s,b_s}`. A register `prev` holds the previous `{a_s,b_s}`.
- Decode, every cycle, comparing `prev` with `{a_s,b_s}`:
  - Forward Gray order is 00→01→11→10→00; each forward step adds 1 to `position`.
  - Each reverse step subtracts 1.
  - No change: `position` holds.
  - Both bits change (illegal): `position` holds, and 16-bit `err_cnt` increments, saturating at 16'hFFFF.
- Arithmetic: `position` is 32-bit two's complement and wraps. 32'h7FFFFFFF + 1 gives 32'h80000000; 0 − 1 gives 32'hFFFFFFFF.
- Status word: [31:16] = `err_cnt`, [15:2] = 0, [1] = `a_s`, [0] = `b_s`.
- Timer: counts down from `UPDATE_CYCLES-1` in IDLE. At 0 it reloads and the FSM enters RD_CMD.
- FSM states and transitions:
  - IDLE: `IO_wEn`=0. Go to RD_CMD when the timer reaches 0.
  - RD_CMD: `IO_addr`=`CMD_ADDR`, `IO_wEn`=0. Go to CHK_CMD.
  - CHK_CMD: `IO_addr`=`CMD_ADDR`; sample `IO_dataIn`. If bit 0 is 1, clear `position` and `err_cnt` this cycle and go to CLR_CMD; otherwise go to WR_POS.
  - CLR_CMD: `IO_addr`=`CMD_ADDR`, `IO_dataOut`=0, `IO_wEn`=1 (acknowledges the command). Go to WR_POS.
  - WR_POS: `IO_addr`=`POS_ADDR`, `IO_dataOut`=`position` as registered at entry to this state, `IO_wEn`=1. Go to WR_STAT.
  - WR_STAT: `IO_addr`=`STATUS_ADDR`, `IO_dataOut`=status word, `IO_wEn`=1. Go to IDLE.
- Decoding never pauses during a sequence. Counts arriving after the WR_POS snapshot appear in the next publish.
- Command word bits [31:1] are ignored.
- This block has exclusive use of the RAM IO port it is connected to. It never drives `IO_wEn` in IDLE, RD_CMD or CHK_CMD.

## Timing
- Reset values: `IO_wEn`=0, `IO_addr`=0, `IO_dataOut`=0, `position`=0, `busy`=0; `err_cnt`=0, `prev`=00, synchronizers=00, timer=`UPDATE_CYCLES-1`, state IDLE.
- `reset_n` low mid-sequence returns to IDLE immediately, with `IO_wEn` low in the same instant. A partially complete sequence is simply abandoned.
- Pin-to-count latency: an edge on `enc_a` that is stable before rising edge N appears on `position` after edge N+2 (two synchronizer stages plus one decode register).
- Publish latency:
  - First publish after reset: RD_CMD is entered `UPDATE_CYCLES` cycles after reset release.
  - A sequence takes 4 cycles without a command and 5 cycles with one.
  - Publish period is exactly `UPDATE_CYCLES` + sequence length, because the timer runs only in IDLE.
- Simultaneous events:
  - Zero command and a decode step in the same CHK_CMD cycle: clear wins, `position`=0, and the step is lost.
  - Illegal transition in that same cycle: `err_cnt`=0.
- `busy` rises in the cycle RD_CMD is entered and falls on return to IDLE.

## Test plan
- Reset and idle: `UPDATE_CYCLES`=8, pins static at 00. Required: first writes are RAM[4000]=0 and RAM[4001]=0; no `IO_wEn` pulse occurs before RD_CMD; `busy`=0 after reset.
- Forward count: apply 10 forward Gray steps, 4 cycles apart. Required: `position`=10 and RAM[4000]=10 after the next publish; each step visible 3 cycles after its pin change.
- Reverse and wrap: from 0, apply 3 reverse steps. Required: `position`=32'hFFFFFFFD. Then preload 32'h7FFFFFFF (via forward steps in a reduced-width sim, or `force`) and apply 1 forward step. Required: 32'h80000000.
- Illegal transition: drive 00→11 directly. Required: `position` unchanged, RAM[4001][31:16]=1, and [1:0]=11.
- Zero command: position = 25, preload RAM[4002]=1. Required: in the next sequence, CLR_CMD writes RAM[4002]=0, then RAM[4000]=0 and `err_cnt`=0; RAM[4002]=32'h2 (bit 0 clear) is ignored.
- Reset mid-sequence: assert `reset_n` low in WR_POS. Required: `IO_wEn` drops immediately, RAM[4001] is not written, all outputs are at reset values, and the next publish occurs `UPDATE_CYCLES` after release.

Source files
------------

// File: rtl/io_encoder_writer.sv
// Quadrature encoder decoder that periodically publishes position/status words
// into data memory over the RAM IO port and polls a mailbox for a zero command.
module io_encoder_writer #(
  parameter int unsigned UPDATE_CYCLES = 100000,
  parameter logic [11:0] POS_ADDR      = 12'd4000,
  parameter logic [11:0] STATUS_ADDR   = 12'd4001,
  parameter logic [11:0] CMD_ADDR      = 12'd4002
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enc_a,
  input  logic        enc_b,
  input  logic [31:0] IO_dataIn,
  output logic [11:0] IO_addr,
  output logic [31:0] IO_dataOut,
  output logic        IO_wEn,
  output logic [31:0] position,
  output logic        busy
);

  localparam int unsigned   TW           = $clog2(UPDATE_CYCLES);
  localparam logic [TW-1:0] TIMER_RELOAD = TW'(UPDATE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_CMD,
    S_CHK_CMD,
    S_CLR_CMD,
    S_WR_POS,
    S_WR_STAT
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    meta_q;
  logic [1:0]    ab_s_q;
  logic [1:0]    prev_q;
  logic [31:0]   position_q, position_d;
  logic [15:0]   err_cnt_q, err_cnt_d;

  logic          step_fwd;
  logic          step_rev;
  logic          step_bad;
  logic          clear_cmd;
  logic [31:0]   status_word;
  logic          unused_cmd_bits;

  // Only bit 0 of the mailbox carries meaning.
  assign unused_cmd_bits = ^IO_dataIn[31:1];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would chain the synchronizer stages into one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q     <= 2'b00;
      ab_s_q     <= 2'b00;
      prev_q     <= 2'b00;
      position_q <= 32'd0;
      err_cnt_q  <= 16'd0;
      timer_q    <= TIMER_RELOAD;
      state_q    <= S_IDLE;
    end else begin
      meta_q     <= {enc_a, enc_b};
      ab_s_q     <= meta_q;
      prev_q     <= ab_s_q;
      position_q <= position_d;
      err_cnt_q  <= err_cnt_d;
      timer_q    <= timer_d;
      state_q    <= state_d;
    end
  end

  // Forward Gray order is 00 -> 01 -> 11 -> 10 -> 00.
  always_comb begin
    step_fwd = ((prev_q == 2'b00) && (ab_s_q == 2'b01)) ||
               ((prev_q == 2'b01) && (ab_s_q == 2'b11)) ||
               ((prev_q == 2'b11) && (ab_s_q == 2'b10)) ||
               ((prev_q == 2'b10) && (ab_s_q == 2'b00));
    step_rev = ((ab_s_q == 2'b00) && (prev_q == 2'b01)) ||
               ((ab_s_q == 2'b01) && (prev_q == 2'b11)) ||
               ((ab_s_q == 2'b11) && (prev_q == 2'b10)) ||
               ((ab_s_q == 2'b10) && (prev_q == 2'b00));
    step_bad = ((prev_q ^ ab_s_q) == 2'b11);
  end

  assign clear_cmd = (state_q == S_CHK_CMD) && IO_dataIn[0];

  // A zero command overrides any decode activity in the same cycle.
  always_comb begin
    position_d = position_q;
    err_cnt_d  = err_cnt_q;
    if (step_fwd) begin
      position_d = position_q + 32'd1;
    end else if (step_rev) begin
      position_d = position_q - 32'd1;
    end
    if (step_bad && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
    if (clear_cmd) begin
      position_d = 32'd0;
      err_cnt_d  = 16'd0;
    end
  end

  assign status_word = {err_cnt_q, 14'd0, ab_s_q};

  // Outputs decode straight from state_q, so an async reset forces IO_wEn low
  // in the same instant without waiting for a clock.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    IO_addr    = 12'd0;
    IO_dataOut = 32'd0;
    IO_wEn     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (timer_q == '0) begin
          timer_d = TIMER_RELOAD;
          state_d = S_RD_CMD;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_RD_CMD: begin
        IO_addr = CMD_ADDR;
        state_d = S_CHK_CMD;
      end
      S_CHK_CMD: begin
        IO_addr = CMD_ADDR;
        state_d = IO_dataIn[0] ? S_CLR_CMD : S_WR_POS;
      end
      S_CLR_CMD: begin
        IO_addr = CMD_ADDR;
        IO_wEn  = 1'b1;
        state_d = S_WR_POS;
      end
      S_WR_POS: begin
        IO_addr    = POS_ADDR;
        IO_dataOut = position_q;
        IO_wEn     = 1'b1;
        state_d    = S_WR_STAT;
      end
      S_WR_STAT: begin
        IO_addr    = STATUS_ADDR;
        IO_dataOut = status_word;
        IO_wEn     = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign position = position_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_io_encoder_writer.sv
// Scoreboard bench for io_encoder_writer: a RAM model on the IO port, expected
// memory writes queued as stimulus is applied and checked as the DUT writes.
`timescale 1ns/1ps
module tb_io_encoder_writer;

  localparam int unsigned U      = 16;
  localparam logic [11:0] POS_A  = 12'd4000;
  localparam logic [11:0] STAT_A = 12'd4001;
  localparam logic [11:0] CMD_A  = 12'd4002;

  logic        clk     = 1'b0;
  logic        reset_n = 1'b1;
  logic        enc_a   = 1'b0;
  logic        enc_b   = 1'b0;
  logic [31:0] io_data_in;
  logic [11:0] io_addr;
  logic [31:0] io_data_out;
  logic        io_wen;
  logic [31:0] position;
  logic        busy;

  io_encoder_writer #(
    .UPDATE_CYCLES(U),
    .POS_ADDR     (POS_A),
    .STATUS_ADDR  (STAT_A),
    .CMD_ADDR     (CMD_A)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enc_a     (enc_a),
    .enc_b     (enc_b),
    .IO_dataIn (io_data_in),
    .IO_addr   (io_addr),
    .IO_dataOut(io_data_out),
    .IO_wEn    (io_wen),
    .position  (position),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // RAM model: one-cycle read latency, write on the rising edge; the bench can
  // post a word into the command mailbox through host_we.
  logic [31:0] ram [0:4095];
  logic        host_we   = 1'b0;
  logic [31:0] host_data = 32'd0;

  always @(posedge clk) begin
    io_data_in <= ram[io_addr];
    if (io_wen) ram[io_addr] <= io_data_out;
    else if (host_we) ram[CMD_A] <= host_data;
  end

  typedef struct packed {
    logic [11:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [1:0]  pins;
  logic [31:0] pos_exp;
  logic [15:0] err_exp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && io_wen) begin
      wr_t e;
      if (sb.size() == 0) begin
        check("spurious_wr_addr", {20'd0, io_addr}, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check("wr_addr", {20'd0, io_addr}, {20'd0, e.addr});
        check("wr_data", io_data_out, e.data);
      end
    end
  end

  function automatic logic [1:0] gray_next(input logic [1:0] p);
    case (p)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] gray_prev(input logic [1:0] p);
    case (p)
      2'b00:   return 2'b10;
      2'b01:   return 2'b00;
      2'b11:   return 2'b01;
      default: return 2'b11;
    endcase
  endfunction

  // Called on a falling edge; checks the count appears exactly three edges later.
  task automatic drive(input logic [1:0] p, input logic [31:0] new_pos);
    logic [31:0] old_pos;
    old_pos = pos_exp;
    {enc_a, enc_b} = p;
    pins = p;
    @(negedge clk);
    @(negedge clk);
    check("latency_before", position, old_pos);
    @(negedge clk);
    check("latency_after", position, new_pos);
    pos_exp = new_pos;
    @(negedge clk);
  endtask

  task automatic fwd();
    drive(gray_next(pins), pos_exp + 32'd1);
  endtask

  task automatic rev();
    drive(gray_prev(pins), pos_exp - 32'd1);
  endtask

  task automatic illegal();
    if (err_exp != 16'hFFFF) err_exp = err_exp + 16'd1;
    drive(pins ^ 2'b11, pos_exp);
  endtask

  task automatic host_write(input logic [31:0] d);
    host_data = d;
    host_we   = 1'b1;
    @(negedge clk);
    host_we   = 1'b0;
  endtask

  task automatic wait_seq(input bit clr);
    int t;
    t = 0;
    while (!busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("seq_start", {31'd0, busy}, 32'd1);
    t = 0;
    while (busy && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("seq_len", t, clr ? 32'd5 : 32'd4);
    check("sb_drained", sb.size(), 32'd0);
  endtask

  task automatic publish(input bit clr);
    if (clr) begin
      sb.push_back('{addr: CMD_A, data: 32'd0});
      pos_exp = 32'd0;
      err_exp = 16'd0;
    end
    sb.push_back('{addr: POS_A,  data: pos_exp});
    sb.push_back('{addr: STAT_A, data: {err_exp, 14'd0, pins}});
    wait_seq(clr);
  endtask

  // Releases reset on a falling edge and times the first entry to RD_CMD.
  task automatic start_after_reset();
    int cnt;
    sb.push_back('{addr: POS_A,  data: 32'd0});
    sb.push_back('{addr: STAT_A, data: {16'd0, 14'd0, pins}});
    reset_n = 1'b1;
    cnt = 0;
    while (!busy && cnt < 1000) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check("first_rd_cmd_cycles", cnt, U);
    @(negedge clk);
    wait_seq(1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t;
    pins    = 2'b00;
    pos_exp = 32'd0;
    err_exp = 16'd0;
    ram[CMD_A] = 32'd0;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_wen",      {31'd0, io_wen}, 32'd0);
    check("rst_addr",     {20'd0, io_addr}, 32'd0);
    check("rst_dout",     io_data_out, 32'd0);
    check("rst_position", position, 32'd0);
    check("rst_busy",     {31'd0, busy}, 32'd0);
    start_after_reset();

    for (int w = 0; w < 4; w++) begin
      for (int s = 0; s < 3; s++) begin
        if (w * 3 + s < 10) fwd();
      end
      publish(1'b0);
    end
    check("pos_fwd10", position, 32'd10);

    host_write(32'd1);
    publish(1'b1);
    check("cmd_acked", ram[CMD_A], 32'd0);
    check("pos_cleared", position, 32'd0);

    host_write(32'd2);
    fwd();
    publish(1'b0);
    check("cmd_bit1_ignored", ram[CMD_A], 32'd2);
    check("pos_after_ignored_cmd", position, 32'd1);

    rev();
    publish(1'b0);
    rev(); rev(); rev();
    check("pos_reverse_wrap", position, 32'hFFFF_FFFD);
    publish(1'b0);

    fwd();
    illegal();
    check("pos_after_illegal", position, 32'hFFFF_FFFE);
    publish(1'b0);

    force dut.position_q = 32'h7FFF_FFFF;
    @(negedge clk);
    release dut.position_q;
    @(negedge clk);
    pos_exp = 32'h7FFF_FFFF;
    check("preload", position, 32'h7FFF_FFFF);
    fwd();
    check("pos_signed_wrap", position, 32'h8000_0000);
    publish(1'b0);

    fwd();
    sb.push_back('{addr: POS_A,  data: pos_exp});
    sb.push_back('{addr: STAT_A, data: {err_exp, 14'd0, pins}});
    t = 0;
    while (!(io_wen && io_addr == POS_A) && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("reach_wr_pos", {20'd0, io_addr}, {20'd0, POS_A});
    #2 reset_n = 1'b0;
    #1;
    check("midrst_wen",      {31'd0, io_wen}, 32'd0);
    check("midrst_busy",     {31'd0, busy}, 32'd0);
    check("midrst_addr",     {20'd0, io_addr}, 32'd0);
    check("midrst_dout",     io_data_out, 32'd0);
    check("midrst_position", position, 32'd0);
    check("stat_not_written", sb.size(), 32'd1);
    sb.delete();
    pos_exp = 32'd0;
    err_exp = 16'd0;
    @(negedge clk);
    @(negedge clk);
    start_after_reset();

    check("sb_empty_end", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
